// File: rtl/axi_slave_resp_pop_fsm.sv
// Read-response pop FSM: drains the response buffer onto the AXI R channel in push order.
// Optional sticky push-while-full flag enabled by defining RESP_POP_OVERFLOW_CHECK_EN.
module axi_slave_resp_pop_fsm #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             push,
    output logic [ADDR_WIDTH:0]              count,
    output logic                             full,
    output logic                             empty,
    output logic                             overflow,
    output logic                             buf_rd_en,
    output logic [ADDR_WIDTH-1:0]            buf_rd_addr,
    input  logic [DATA_WIDTH+ID_WIDTH+2:0]   buf_rd_data,
    output logic                             RVALID,
    input  logic                             RREADY,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [ID_WIDTH-1:0]              RID,
    output logic [1:0]                       RRESP,
    output logic                             RLAST
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     count_next;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                 pop;
    logic                 push_acc;

    assign pop      = RVALID & RREADY;
    // A pop in the same cycle frees a slot, so a push against a full buffer is still taken then.
    assign push_acc = push & (~full | pop);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign buf_rd_addr = rd_ptr;

    always_comb begin
        count_next = count;
        unique case ({push_acc, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        buf_rd_en  = 1'b0;
        unique case (state)
            IDLE: begin
                buf_rd_en = (count != '0);
                if (buf_rd_en) state_next = FETCH;
            end
            FETCH: state_next = SEND;
            SEND: begin
                if (pop) begin
                    // count includes the beat on R; fetch again if anything remains after it.
                    buf_rd_en  = (count > CNT_W'(1)) | push;
                    state_next = buf_rd_en ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            RVALID <= 1'b0;
            RDATA  <= '0;
            RID    <= '0;
            RRESP  <= '0;
            RLAST  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (buf_rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (state == FETCH) begin
                {RLAST, RRESP, RID, RDATA} <= buf_rd_data;
                RVALID <= 1'b1;
            end else if (pop) begin
                RVALID <= 1'b0;
            end
        end
    end

`ifdef RESP_POP_OVERFLOW_CHECK_EN
    always_ff @(posedge clk or negedge arst) begin
        if (!arst)                     overflow <= 1'b0;
        else if (push & full & ~pop)   overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_axi_slave_resp_pop_fsm.sv
// Directed bench for axi_slave_resp_pop_fsm with a behavioural response buffer and an in-order scoreboard.
module tb_axi_slave_resp_pop_fsm;

    localparam int DW = 64;
    localparam int IW = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int BW = DW + IW + 3;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic push = 1'b0;
    logic RREADY = 1'b0;
    logic [BW-1:0] wdata = '0;
    logic [BW-1:0] buf_rd_data;
    logic [AW:0] count;
    logic full, empty, overflow, buf_rd_en, RVALID, RLAST;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] RDATA;
    logic [IW-1:0] RID;
    logic [1:0] RRESP;

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    axi_slave_resp_pop_fsm #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst), .push(push), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
        .RID(RID), .RRESP(RRESP), .RLAST(RLAST)
    );

    // Response buffer: sync read, write-first on same-address collision; push-FSM skips dropped pushes.
    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            wptr <= '0;
            buf_rd_data <= '0;
        end else begin
            if (push && (!full || (RVALID && RREADY))) begin
                mem[wptr] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (buf_rd_en)
                buf_rd_data <= (push && wptr == buf_rd_addr) ? wdata : mem[buf_rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: inputs change just after posedge, so negedge sees the pending handshake.
    always @(negedge clk) begin
        if (arst && RVALID && RREADY) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
            else chk("beat", 128'({RLAST, RRESP, RID, RDATA}), 128'(exp_q.pop_front()));
        end
    end

    function automatic logic [BW-1:0] mk(input logic l, input logic [1:0] r, input logic [IW-1:0] id,
                                         input logic [DW-1:0] d);
        return {l, r, id, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [BW-1:0] b, input bit accepted);
        push = 1'b1;
        wdata = b;
        if (accepted) exp_q.push_back(b);
        step();
        push = 1'b0;
    endtask

    initial begin
        int hs0;
        logic exp_ovf;
`ifdef RESP_POP_OVERFLOW_CHECK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // Reset held with push asserted
        push = 1'b1;
        repeat (3) step();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_rvalid", 128'(RVALID), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_ptr", 128'(buf_rd_addr), 128'(0));
        chk("rst_rden", 128'(buf_rd_en), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_rdata", 128'(RDATA), 128'(0));
        push = 1'b0;
        arst = 1'b1;
        step();

        // Single beat
        RREADY = 1'b1;
        push_one(mk(1'b1, 2'd0, 4'd5, 64'hA5), 1'b1);
        chk("sb_count1", 128'(count), 128'(1));
        chk("sb_rden", 128'(buf_rd_en), 128'(1));
        chk("sb_rvalid0", 128'(RVALID), 128'(0));
        step();
        chk("sb_fetch_rvalid", 128'(RVALID), 128'(0));
        chk("sb_fetch_rden", 128'(buf_rd_en), 128'(0));
        step();
        chk("sb_rvalid1", 128'(RVALID), 128'(1));
        chk("sb_rid", 128'(RID), 128'(5));
        chk("sb_rdata", 128'(RDATA), 128'(64'hA5));
        chk("sb_rlast", 128'(RLAST), 128'(1));
        chk("sb_no_refetch", 128'(buf_rd_en), 128'(0));
        step();
        chk("sb_count0", 128'(count), 128'(0));
        chk("sb_empty", 128'(empty), 128'(1));
        chk("sb_rvalid_clr", 128'(RVALID), 128'(0));
        chk("sb_hs", 128'(hs_cnt), 128'(1));

        // Backpressure: 4 beats, RREADY low for 10 cycles
        RREADY = 1'b0;
        for (int i = 0; i < 4; i++)
            push_one(mk(i == 3, 2'(i), 4'(i + 8), 64'h1000 + 64'(i)), 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_rvalid", 128'(RVALID), 128'(1));
            chk("bp_rdata", 128'(RDATA), 128'(64'h1000));
        end
        chk("bp_count", 128'(count), 128'(4));
        hs0 = hs_cnt;
        RREADY = 1'b1;
        repeat (8) step();
        chk("bp_hs", 128'(hs_cnt - hs0), 128'(4));
        chk("bp_count0", 128'(count), 128'(0));

        // Fill to full, overflow, drain with pointer wrap
        arst = 1'b0;
        step();
        arst = 1'b1;
        exp_q.delete();
        RREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1;
            wdata = mk(i == DEPTH - 1, 2'd1, 4'(i), 64'hBEEF0000 + 64'(i));
            exp_q.push_back(wdata);
            step();
        end
        push = 1'b0;
        chk("full_flag", 128'(full), 128'(1));
        chk("full_count", 128'(count), 128'(16));
        chk("full_ovf0", 128'(overflow), 128'(0));
        push_one(mk(1'b0, 2'd3, 4'hF, 64'hDEAD), 1'b0);
        chk("ovf_count", 128'(count), 128'(16));
        chk("ovf_flag", 128'(overflow), 128'(exp_ovf));
        hs0 = hs_cnt;
        RREADY = 1'b1;
        repeat (2 * DEPTH) step();
        chk("drain_hs", 128'(hs_cnt - hs0), 128'(16));
        chk("drain_count", 128'(count), 128'(0));
        chk("drain_empty", 128'(empty), 128'(1));
        chk("drain_ptr_wrap", 128'(buf_rd_addr), 128'(0));
        chk("drain_ovf_sticky", 128'(overflow), 128'(exp_ovf));

        // Simultaneous push and pop with one beat held in SEND
        RREADY = 1'b0;
        push_one(mk(1'b0, 2'd0, 4'd1, 64'hAAAA), 1'b1);
        repeat (2) step();
        chk("pp_rvalid", 128'(RVALID), 128'(1));
        chk("pp_count", 128'(count), 128'(1));
        RREADY = 1'b1;
        push = 1'b1;
        wdata = mk(1'b1, 2'd2, 4'd2, 64'hBBBB);
        exp_q.push_back(wdata);
        #1;
        chk("pp_rden", 128'(buf_rd_en), 128'(1));
        step();
        push = 1'b0;
        chk("pp_count_hold", 128'(count), 128'(1));
        chk("pp_fetch", 128'(RVALID), 128'(0));
        step();
        chk("pp_rvalid2", 128'(RVALID), 128'(1));
        chk("pp_rdata2", 128'(RDATA), 128'(64'hBBBB));
        step();
        chk("pp_count0", 128'(count), 128'(0));

        // Asynchronous reset while in SEND with count 3
        RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            wdata = mk(1'b0, 2'd0, 4'd7, 64'hC0 + 64'(i));
            exp_q.push_back(wdata);
            step();
        end
        push = 1'b0;
        chk("ar_rvalid", 128'(RVALID), 128'(1));
        chk("ar_count", 128'(count), 128'(3));
        #2;
        arst = 1'b0;
        #1;
        chk("ar_rvalid_clr", 128'(RVALID), 128'(0));
        chk("ar_count_clr", 128'(count), 128'(0));
        chk("ar_rdata_clr", 128'(RDATA), 128'(0));
        chk("ar_empty", 128'(empty), 128'(1));
        chk("ar_ptr_clr", 128'(buf_rd_addr), 128'(0));
        exp_q.delete();
        step();
        arst = 1'b1;
        RREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ar_no_stale", 128'({RVALID, buf_rd_en}), 128'(0));
        end
        chk("ar_count_final", 128'(count), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_slave_resp_pop_fsm.md
# axi_slave_resp_pop_fsm

Drains the AXI slave read-response buffer onto the AXI R channel. Counterpart of the response-path push FSM: the push side writes beats into the buffer and pulses `push`; this block tracks buffer occupancy with an internal up/down counter, reads entries in order through a wrapping read pointer, and presents each beat on R with a full VALID/READY handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 64, RDATA width.
- `ID_WIDTH`, 4, RID width.
- `DEPTH`, 16, buffer entries; power of two, ≥ 2.
- `ADDR_WIDTH`, $clog2(DEPTH), read-pointer width (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `arst` in 1: asynchronous active-low reset.
- `push` in 1: one beat written to buffer this cycle (from push FSM).
- `count` out ADDR_WIDTH+1: entries not yet accepted on R (includes beat held on R).
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky push-while-full flag (see Configuration).
- `buf_rd_en` out 1: buffer read strobe.
- `buf_rd_addr` out ADDR_WIDTH: buffer read address (= read pointer).
- `buf_rd_data` in DATA_WIDTH+ID_WIDTH+3: {RLAST, RRESP[1:0], RID, RDATA}, valid the cycle after `buf_rd_en`.
- `RVALID` out 1, `RREADY` in 1, `RDATA` out DATA_WIDTH, `RID` out ID_WIDTH, `RRESP` out 2, `RLAST` out 1: AXI R channel.

## Operation
- Reset: state IDLE, `count`=0, read pointer 0, `RVALID`=0, `RDATA`/`RID`/`RRESP`/`RLAST`=0, `buf_rd_en`=0, `overflow`=0, `empty`=1, `full`=0.
- Occupancy counter: `pop` = `RVALID & RREADY`. `push` only → +1; `pop` only → −1; both → unchanged. `push` while `full` and no same-cycle pop is dropped; count stays DEPTH.
- Read pointer increments (mod DEPTH, wraps DEPTH−1 → 0) every cycle `buf_rd_en` is asserted.
- FSM (`buf_rd_en` is combinational from state/inputs):
  - IDLE: `buf_rd_en` = (`count` ≠ 0). If asserted → FETCH, else stay.
  - FETCH: `buf_rd_data` valid; at clock edge load R output registers, set `RVALID`=1 → SEND.
  - SEND: `RVALID`=1; R fields stable until handshake. On `pop`: if `count − 1 + push` > 0, assert `buf_rd_en` this cycle → FETCH; else → IDLE. `RVALID` clears at that edge. No pop → stay.
- `RVALID` never deasserts without handshake; `RREADY` may toggle freely.
- Beats issued strictly in push order; RLAST/RRESP/RID passed through unmodified.

## Timing
- Push at edge E0 into empty block: `count`=1 after E0; `buf_rd_en` high cycle E0→E1; `RVALID` high after E2. Push-to-RVALID latency: 2 cycles after `count` goes nonzero.
- Back-to-back throughput: one beat per 2 cycles (SEND, FETCH alternate) with `RREADY` held high.
- Reset mid-burst: all state cleared immediately (asynchronous); beats in flight are lost; `RVALID` drops without handshake (permitted only under reset).
- `count`, `full`, `empty` update on the edge following push/pop; `full`/`empty` decoded from registered `count`.

## Configuration
- `RESP_POP_OVERFLOW_CHECK_EN` defined: `overflow` sets on any cycle with `push & full & ~pop`, stays set until reset; push dropped.
- Undefined: `overflow` tied 0; push while full still dropped, no flag logic synthesized.

## Test plan
- Reset: hold `arst`=0 with `push`=1 for 3 cycles → `count`=0, `RVALID`=0, `empty`=1, pointer 0.
- Single beat: push {RLAST=1, RRESP=0, RID=5, RDATA=0xA5} with `RREADY`=1 → `RVALID` 2 cycles after `count`=1, fields match, one handshake, return to IDLE, `count`=0.
- Backpressure: 4 beats pushed, `RREADY`=0 for 10 cycles → `RVALID` held, first beat stable, `count`=4; release `RREADY` → 4 beats in order, 8 cycles, last with RLAST=1.
- Wrap/full: push DEPTH=16 beats with `RREADY`=0 → `full`=1; 17th push → `count` stays 16, `overflow`=1 (macro on) / 0 (off); drain 16 → data in order, pointer wraps to 0.
- Simultaneous push/pop at `count`=1 in SEND → `count` stays 1, next `buf_rd_en` issued, next beat follows without IDLE.
- Async reset asserted while in SEND with `count`=3 → outputs to reset values same cycle; after release, no stale beat appears.
